// File: rtl/sqr_arb.sv
// Round-robin arbiter sharing one LEN x LEN unsigned squarer among four requesters.
// One request is in flight at a time: IDLE grants, COMPUTE squares, HOLD presents the result.
module sqr_arb #(
  parameter int unsigned LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [4*LEN-1:0] req_x,
  output logic [3:0]       req_ready,
  output logic             rsp_valid,
  output logic [1:0]       rsp_id,
  output logic [2*LEN-1:0] rsp_y,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int unsigned NReq = 4;

  typedef enum logic [1:0] {StIdle, StCompute, StHold} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q;
  logic [LEN-1:0]   op_q;
  logic [1:0]       id_q;
  logic             grant_any;
  logic [1:0]       grant_idx;
  logic [2*LEN-1:0] op_ext;

  // First set request at or above the pointer, wrapping modulo 4.
  always_comb begin
    logic [1:0] idx;
    grant_any = 1'b0;
    grant_idx = ptr_q;
    for (int k = 0; k < NReq; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (grant_any) state_d = StCompute;
      StCompute: state_d = StHold;
      StHold:    if (rsp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
    busy = (state_q != StIdle);
  end

  assign op_ext = {{LEN{1'b0}}, op_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      op_q      <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
    end else begin
      if (state_q == StIdle && grant_any) begin
        op_q  <= req_x[grant_idx*LEN +: LEN];
        id_q  <= grant_idx;
        ptr_q <= grant_idx + 2'd1;
      end
      if (state_q == StCompute) begin
        rsp_y     <= op_ext * op_ext;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if (state_q == StHold && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sqr_arb.sv
// Bench for sqr_arb: directed scenarios plus random traffic, checked each cycle against a
// transaction-level model (modulo pointer search, integer squaring, phase countdown).
module tb_sqr_arb;

  localparam int unsigned LEN = 16;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [4*LEN-1:0] req_x;
  logic [3:0]       req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [2*LEN-1:0] rsp_y;
  logic             rsp_ready;
  logic             busy;

  sqr_arb #(.LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = waiting for grant, 1 = squaring, 2 = result on offer.
  int              m_phase;
  int              m_ptr;
  int              m_id;
  int              m_rid;
  longint unsigned m_op;
  longint unsigned m_y;
  bit              m_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_grant(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_id    = 0;
    m_rid   = 0;
    m_op    = 0;
    m_y     = 0;
    m_valid = 0;
  endtask

  // One clock cycle: drive, compare, then advance the model past the coming rising edge.
  task automatic step(input logic [3:0] v, input logic [63:0] x, input logic rr);
    int g;
    logic [3:0] exp_rdy;
    @(negedge clk);
    req_valid = v;
    req_x     = x;
    rsp_ready = rr;
    #1;
    g = (m_phase == 0) ? exp_grant(v, m_ptr) : -1;
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, m_valid);
    check("rsp_y", rsp_y, m_y);
    check("rsp_id", rsp_id, m_rid);
    check("busy", busy, m_phase != 0);
    case (m_phase)
      0: if (g >= 0) begin
        m_op    = (x >> (g * LEN)) & 64'hFFFF;
        m_id    = g;
        m_ptr   = (g + 1) % 4;
        m_phase = 1;
      end
      1: begin
        m_y     = m_op * m_op;
        m_rid   = m_id;
        m_valid = 1;
        m_phase = 2;
      end
      default: if (rr) begin
        m_valid = 0;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_y", rsp_y, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int order[5];
    logic [3:0]  v;
    logic [63:0] x;
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("init_rsp_valid", rsp_valid, 0);
    check("init_busy", busy, 0);
    rst_n = 1'b1;

    // Single request, operand 3.
    step(4'b0001, 64'h3, 1'b1);
    check("single_ready", req_ready, 4'b0001);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0000, 64'h0, 1'b1);
    check("single_y", rsp_y, 9);
    check("single_id", rsp_id, 0);
    step(4'b0000, 64'h0, 1'b1);

    // Round-robin with operands 1,2,3,4; pointer is 1 here, so reset first.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
      if (i % 3 == 0) check("rr_order", req_ready, 4'b0001 << order[i / 3]);
    end

    // Back-pressure with the largest operand.
    do_reset();
    step(4'b0001, 64'hFFFF, 1'b0);
    step(4'b0000, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 64'h0, 1'b0);
      check("bp_y", rsp_y, 64'hFFFE0001);
      check("bp_valid", rsp_valid, 1);
    end
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0000, 64'h0, 1'b0);
    check("bp_idle", busy, 0);

    // Zero operand.
    step(4'b0010, 64'hFFFF_FFFF_0000_FFFF, 1'b1);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0000, 64'h0, 1'b1);
    check("zero_y", rsp_y, 0);

    // Pointer skip: grant 1 makes ptr 2, then 0011 must grant 0, then 1.
    do_reset();
    step(4'b0010, 64'h5_0000, 1'b1);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0011, 64'h7_0006, 1'b1);
    check("skip_grant0", req_ready, 4'b0001);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0011, 64'h7_0006, 1'b1);
    check("skip_grant1", req_ready, 4'b0010);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0000, 64'h0, 1'b1);

    // Reset mid-HOLD, then first grant from requester 0.
    step(4'b1000, 64'h1234_0000_0000_0000, 1'b0);
    step(4'b0000, 64'h0, 1'b0);
    step(4'b0000, 64'h0, 1'b0);
    check("hold_before_rst", rsp_valid, 1);
    do_reset();
    step(4'b0000, 64'h0, 1'b1);
    step(4'b1111, 64'h0, 1'b1);
    check("post_rst_grant", req_ready, 4'b0001);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0000, 64'h0, 1'b1);

    // Withdrawn request from requester 2 while busy; ptr must stay at 2.
    step(4'b0010, 64'h9_0000, 1'b1);
    step(4'b0100, 64'h0, 1'b1);
    step(4'b0100, 64'h0, 1'b0);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b1111, 64'h0, 1'b1);
    check("withdraw_ptr", req_ready, 4'b0100);
    step(4'b0000, 64'h0, 1'b1);
    step(4'b0000, 64'h0, 1'b1);

    // Random traffic with boundary operands and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      v = 4'($urandom);
      x = {$urandom, $urandom};
      for (int r = 0; r < 4; r++) begin
        case ($urandom_range(7))
          0: x[r*LEN +: LEN] = 16'hFFFF;
          1: x[r*LEN +: LEN] = 16'h0000;
          default: ;
        endcase
      end
      step(v, x, $urandom_range(3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
